disp_bebida: RTL and testbench
==============================

DISP_BEBIDA -- requirements
Module: disp_bebida

Interface
REQ-001 Parameter T_AGUA, default 4, water-phase duration in clock cycles (legal range 1..15).
REQ-002 Parameter T_POLVO, default 2, coffee/chocolate powder-phase duration in cycles (legal range 1..15).
REQ-003 Parameter T_LECHE, default 3, milk-phase duration in cycles (legal range 1..15).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-low.
REQ-006 start  in  1  order request, sampled only in IDLE.
REQ-007 bebida  in  2  drink code: 00 black coffee, 01 coffee with milk, 10 cappuccino, 11 chocolate.
REQ-008 enable_fin  in  1  completion flag from the downstream sugar stage.
REQ-009 cancelar  in  1  abort request; present only when CANCEL_EN is defined.
REQ-010 led_agua, led_cafe, led_choco, led_leche  out  1 each  valve/LED drive per ingredient.
REQ-011 enable_azucar  out  1  enable for the sugar stage.
REQ-012 bebida_out  out  2  latched drink code forwarded to the sugar stage.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 listo  out  1  one-cycle pulse when an order completes.

Function
REQ-015 FSM states: IDLE, AGUA, POLVO, LECHE, AZUCAR; registered, one-hot or binary at implementer's choice.
REQ-016 IDLE with start=1 at edge k: latch bebida into bebida_out, enter AGUA at edge k; led_agua high for exactly T_AGUA cycles starting the cycle after edge k.
REQ-017 AGUA -> POLVO after T_AGUA cycles; POLVO drives led_cafe for codes 00/01/10, led_choco for code 11, for exactly T_POLVO cycles.
REQ-018 POLVO -> LECHE for codes 01/11 (T_LECHE cycles) and 10 (2*T_LECHE cycles); POLVO -> AZUCAR directly for code 00.
REQ-019 Phase counter 5 bits wide, cleared on every state entry; 2*T_LECHE (max 30) shall not overflow.
REQ-020 AZUCAR: enable_azucar=1 and bebida_out held until enable_fin sampled 1; on that edge go to IDLE, listo=1 for the following single cycle.
REQ-021 enable_fin already high on the first AZUCAR cycle: exit AZUCAR at the end of that cycle (enable_azucar high for exactly one cycle).
REQ-022 enable_fin outside AZUCAR is ignored.
REQ-023 start outside IDLE is ignored; start and bebida changes never alter an order in progress.
REQ-024 start held high continuously: a new order starts in the cycle after listo (IDLE lasts one cycle).
REQ-025 At most one of led_agua, led_cafe, led_choco, led_leche is high in any cycle; all are low in IDLE and AZUCAR.
REQ-026 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst=0 at a rising edge forces IDLE, counter=0, all LEDs=0, enable_azucar=0, busy=0, listo=0, bebida_out=00, regardless of state (reset mid-order aborts without listo).
REQ-028 rst has priority over start, enable_fin and cancelar in the same cycle.

Configuration
REQ-029 Macro DISP_BEBIDA_CANCEL_EN defined: cancelar port exists; cancelar=1 at an edge in any non-IDLE state forces IDLE next cycle with all LEDs, enable_azucar and listo low, bebida_out unchanged; cancelar in IDLE ignored; cancelar has priority over start and enable_fin.
REQ-030 Macro undefined: no cancelar port; behaviour identical to REQ-015..028.

Verification
REQ-031 Defaults, bebida=00, start pulse at edge 0, enable_fin=1 at edge 7 -> led_agua cycles 1-4, led_cafe 5-6, enable_azucar cycle 7 only, listo cycle 8, busy cycles 1-7, led_leche never high.
REQ-032 Defaults, bebida=10, enable_fin tied 1 -> led_agua 4 cycles, led_cafe 2, led_leche 6, enable_azucar 1 cycle, listo 1 cycle; bebida_out=10 throughout.
REQ-033 bebida=11, enable_fin held 0 for 20 cycles -> led_choco 2 cycles, led_leche 3 cycles, enable_azucar stays high 20 cycles, start pulses during order ignored.
REQ-034 bebida=01, rst=0 on 3rd led_leche cycle -> next cycle all outputs 0, busy=0, no listo pulse.
REQ-035 CANCEL_EN defined, bebida=01, cancelar=1 on 2nd led_agua cycle -> IDLE next cycle, no POLVO/LEHCE/AZUCAR activity, no listo.
REQ-036 start held 1, bebida=00, enable_fin tied 1 -> back-to-back orders, 8-cycle period, listo every 8th cycle.

Source files
------------

// File: rtl/disp_bebida.sv
// rtl/disp_bebida.sv - drink dispenser sequencer (water, powder, milk, sugar handoff); optional abort via DISP_BEBIDA_CANCEL_EN
module disp_bebida #(
  parameter int T_AGUA  = 4,
  parameter int T_POLVO = 2,
  parameter int T_LECHE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] bebida,
  input  logic       enable_fin,
`ifdef DISP_BEBIDA_CANCEL_EN
  input  logic       cancelar,
`endif
  output logic       led_agua,
  output logic       led_cafe,
  output logic       led_choco,
  output logic       led_leche,
  output logic       enable_azucar,
  output logic [1:0] bebida_out,
  output logic       busy,
  output logic       listo
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AGUA   = 3'd1,
    POLVO  = 3'd2,
    LECHE  = 3'd3,
    AZUCAR = 3'd4
  } state_t;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [4:0] LAST_AGUA   = 5'(T_AGUA - 1);
  localparam logic [4:0] LAST_POLVO  = 5'(T_POLVO - 1);
  localparam logic [4:0] LAST_LECHE  = 5'(T_LECHE - 1);
  localparam logic [4:0] LAST_LECHE2 = 5'(2 * T_LECHE - 1);

  localparam logic [1:0] COD_NEGRO = 2'b00;
  localparam logic [1:0] COD_CAPUC = 2'b10;
  localparam logic [1:0] COD_CHOCO = 2'b11;

  state_t     state, state_n;
  logic [4:0] cnt;
  logic [4:0] last;
  logic       listo_n;

  // Next-state decision; outputs are registered from state_n below.
  always_comb begin
    state_n = state;
    listo_n = 1'b0;
    last    = 5'd0;
    case (state)
      IDLE: begin
        if (start) state_n = AGUA;
      end
      AGUA: begin
        last = LAST_AGUA;
        if (cnt == last) state_n = POLVO;
      end
      POLVO: begin
        last = LAST_POLVO;
        if (cnt == last) state_n = (bebida_out == COD_NEGRO) ? AZUCAR : LECHE;
      end
      LECHE: begin
        last = (bebida_out == COD_CAPUC) ? LAST_LECHE2 : LAST_LECHE;
        if (cnt == last) state_n = AZUCAR;
      end
      AZUCAR: begin
        if (enable_fin) begin
          state_n = IDLE;
          listo_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef DISP_BEBIDA_CANCEL_EN
    if (cancelar && state != IDLE) begin
      state_n = IDLE;
      listo_n = 1'b0;
    end
`endif
  end

  // State, phase counter and registered output decode of the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      led_agua      <= 1'b0;
      led_cafe      <= 1'b0;
      led_choco     <= 1'b0;
      led_leche     <= 1'b0;
      enable_azucar <= 1'b0;
      bebida_out    <= 2'b00;
      busy          <= 1'b0;
      listo         <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || state_n == IDLE || state_n == AZUCAR)
        cnt <= 5'd0;
      else
        cnt <= cnt + 5'd1;
      // The code is latched at order acceptance; POLVO is never entered in the same edge,
      // so comparing the held bebida_out there is safe.
      if (state == IDLE && start)
        bebida_out <= bebida;
      led_agua      <= (state_n == AGUA);
      led_cafe      <= (state_n == POLVO) && (bebida_out != COD_CHOCO);
      led_choco     <= (state_n == POLVO) && (bebida_out == COD_CHOCO);
      led_leche     <= (state_n == LECHE);
      enable_azucar <= (state_n == AZUCAR);
      busy          <= (state_n != IDLE);
      listo         <= listo_n;
    end
  end

endmodule

// File: tb/tb_disp_bebida.sv
// tb/tb_disp_bebida.sv - directed table-driven bench for disp_bebida
`timescale 1ns/1ps
module tb_disp_bebida;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] bebida;
  logic       enable_fin;
  logic       cancelar;
  logic       led_agua, led_cafe, led_choco, led_leche;
  logic       enable_azucar, busy, listo;
  logic [1:0] bebida_out;

  int checks = 0;
  int errors = 0;

  disp_bebida dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bebida(bebida),
    .enable_fin(enable_fin),
`ifdef DISP_BEBIDA_CANCEL_EN
    .cancelar(cancelar),
`endif
    .led_agua(led_agua),
    .led_cafe(led_cafe),
    .led_choco(led_choco),
    .led_leche(led_leche),
    .enable_azucar(enable_azucar),
    .bebida_out(bebida_out),
    .busy(busy),
    .listo(listo)
  );

  always #5 clk = ~clk;

  // Expected output word: {agua, cafe, choco, leche, azucar, busy, listo}
  localparam logic [6:0] I = 7'b0000000;
  localparam logic [6:0] A = 7'b1000010;
  localparam logic [6:0] C = 7'b0100010;
  localparam logic [6:0] H = 7'b0010010;
  localparam logic [6:0] M = 7'b0001010;
  localparam logic [6:0] Z = 7'b0000110;
  localparam logic [6:0] L = 7'b0000001;

  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] beb;
    logic       fin;
    logic [6:0] exp;
    logic [1:0] bo;
    string      tag;
  } vec_t;

  vec_t vq[$];

  task automatic add_n(input int n, input logic r, input logic s, input logic [1:0] b,
                       input logic f, input logic [6:0] e, input logic [1:0] bo, input string tag);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = r; v.start = s; v.beb = b; v.fin = f; v.exp = e; v.bo = bo; v.tag = tag;
      vq.push_back(v);
    end
  endtask

  function automatic logic [6:0] outs();
    return {led_agua, led_cafe, led_choco, led_leche, enable_azucar, busy, listo};
  endfunction

  task automatic check(input string tag, input logic [6:0] exp, input logic [1:0] bo);
    checks++;
    if (outs() !== exp || bebida_out !== bo) begin
      errors++;
      $display("FAIL %s: outs=%b bebida_out=%b, expected outs=%b bebida_out=%b",
               tag, outs(), bebida_out, exp, bo);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; bebida = 2'b00; enable_fin = 1'b0; cancelar = 1'b0;

    // reset and reset priority over start
    add_n(1, 0, 0, 2'b00, 0, I, 2'b00, "reset");
    add_n(1, 0, 1, 2'b10, 1, I, 2'b00, "rst_over_start");
    // black coffee, enable_fin at the 8th edge
    add_n(1, 1, 1, 2'b00, 0, A, 2'b00, "c00_agua");
    add_n(3, 1, 0, 2'b00, 0, A, 2'b00, "c00_agua");
    add_n(2, 1, 0, 2'b00, 0, C, 2'b00, "c00_cafe");
    add_n(1, 1, 0, 2'b00, 0, Z, 2'b00, "c00_azucar");
    add_n(1, 1, 0, 2'b00, 1, L, 2'b00, "c00_listo");
    add_n(1, 1, 0, 2'b00, 0, I, 2'b00, "c00_idle");
    // cappuccino, enable_fin tied high, start/bebida wiggled mid-order
    add_n(1, 1, 1, 2'b10, 1, A, 2'b10, "c10_agua");
    add_n(1, 1, 1, 2'b01, 1, A, 2'b10, "c10_agua_restart");
    add_n(2, 1, 0, 2'b11, 1, A, 2'b10, "c10_agua");
    add_n(2, 1, 0, 2'b10, 1, C, 2'b10, "c10_cafe");
    add_n(6, 1, 0, 2'b10, 1, M, 2'b10, "c10_leche");
    add_n(1, 1, 0, 2'b10, 1, Z, 2'b10, "c10_azucar");
    add_n(1, 1, 0, 2'b10, 1, L, 2'b10, "c10_listo");
    add_n(1, 1, 0, 2'b10, 0, I, 2'b10, "c10_idle");
    // chocolate, sugar stage stalls for 20 cycles, start held meanwhile
    add_n(1, 1, 1, 2'b11, 0, A, 2'b11, "c11_agua");
    add_n(3, 1, 0, 2'b11, 0, A, 2'b11, "c11_agua");
    add_n(2, 1, 0, 2'b11, 0, H, 2'b11, "c11_choco");
    add_n(3, 1, 0, 2'b11, 0, M, 2'b11, "c11_leche");
    add_n(20, 1, 1, 2'b00, 0, Z, 2'b11, "c11_azucar_wait");
    add_n(1, 1, 0, 2'b11, 1, L, 2'b11, "c11_listo");
    add_n(1, 1, 0, 2'b11, 0, I, 2'b11, "c11_idle");
    // coffee with milk, full order
    add_n(1, 1, 1, 2'b01, 1, A, 2'b01, "c01_agua");
    add_n(3, 1, 0, 2'b01, 1, A, 2'b01, "c01_agua");
    add_n(2, 1, 0, 2'b01, 1, C, 2'b01, "c01_cafe");
    add_n(3, 1, 0, 2'b01, 1, M, 2'b01, "c01_leche");
    add_n(1, 1, 0, 2'b01, 1, Z, 2'b01, "c01_azucar");
    add_n(1, 1, 0, 2'b01, 1, L, 2'b01, "c01_listo");
    // coffee with milk, reset during third milk cycle
    add_n(1, 1, 1, 2'b01, 0, A, 2'b01, "rst_mid_agua");
    add_n(3, 1, 0, 2'b01, 0, A, 2'b01, "rst_mid_agua");
    add_n(2, 1, 0, 2'b01, 0, C, 2'b01, "rst_mid_cafe");
    add_n(3, 1, 0, 2'b01, 0, M, 2'b01, "rst_mid_leche");
    add_n(1, 0, 0, 2'b01, 1, I, 2'b00, "rst_mid_abort");
    add_n(1, 1, 0, 2'b01, 1, I, 2'b00, "rst_mid_nolisto");
    // start held: back-to-back black coffees, 8-cycle period
    for (int o = 0; o < 3; o++) begin
      add_n(4, 1, 1, 2'b00, 1, A, 2'b00, "b2b_agua");
      add_n(2, 1, 1, 2'b00, 1, C, 2'b00, "b2b_cafe");
      add_n(1, 1, 1, 2'b00, 1, Z, 2'b00, "b2b_azucar");
      add_n(1, 1, 0, 2'b00, 1, L, 2'b00, "b2b_listo");
    end
    add_n(1, 1, 0, 2'b00, 1, I, 2'b00, "b2b_idle");

    @(negedge clk);
    foreach (vq[i]) begin
      rst = vq[i].rst; start = vq[i].start; bebida = vq[i].beb; enable_fin = vq[i].fin;
      step();
      check(vq[i].tag, vq[i].exp, vq[i].bo);
    end

    // listo latency for a black coffee, bounded wait
    rst = 1'b1; start = 1'b1; bebida = 2'b00; enable_fin = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!listo && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!listo || n != 8) begin
      errors++;
      $display("FAIL listo_latency: cycles=%0d listo=%b, expected cycles=8 listo=1", n, listo);
    end
    step();

`ifdef DISP_BEBIDA_CANCEL_EN
    // abort on the second water cycle
    enable_fin = 1'b0; bebida = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    check("cancel_agua1", A, 2'b01);
    step();
    check("cancel_agua2", A, 2'b01);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    check("cancel_idle", I, 2'b01);
    for (int k = 0; k < 12; k++) begin
      step();
      check("cancel_quiet", I, 2'b01);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
